// File: rtl/msi_univ_counter.sv
// ----------------------------------------------------------------------------
// msi_univ_counter
//   Universal WIDTH-bit register/counter: hold, parallel load, up/down count
//   with programmable modulus, shift left/right, rotate left and synchronous
//   clear. Terminal count is combinational.
//
//   Parameters
//     WIDTH      register width (>=1)
//     MODULUS    0 = natural 2^WIDTH wrap, else counts 0..MODULUS-1
//     RESET_VAL  value forced into q by rst
//
//   Ports
//     clk    rising-edge clock
//     rst    asynchronous active-high reset
//     ce     clock enable, 0 freezes q in every mode
//     mode   operation select (HOLD/LOAD/UP/DOWN/SHL/SHR/ROL/CLR)
//     d      parallel load data
//     sl_in  serial input entering bit 0 on shift-left
//     sr_in  serial input entering bit WIDTH-1 on shift-right
//     q      register contents
//     tc     terminal count (combinational)
//
//   Optional macro RV523_CASCADE_EN adds cin/cout for ripple chaining:
//   UP/DOWN advance only with cin=1, tc is gated by cin, cout = tc.
// ----------------------------------------------------------------------------
module msi_univ_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic             tc
`ifdef RV523_CASCADE_EN
    ,
    input  logic             cin,
    output logic             cout
`endif
);

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_UP   = 3'd2;
    localparam logic [2:0] MODE_DOWN = 3'd3;
    localparam logic [2:0] MODE_SHL  = 3'd4;
    localparam logic [2:0] MODE_SHR  = 3'd5;
    localparam logic [2:0] MODE_ROL  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    // A modulus of exactly 2^WIDTH behaves like the natural wrap.
    localparam bit NATURAL = (MODULUS == 0) ||
                             (64'(MODULUS) == (64'd1 << WIDTH));
    localparam logic [WIDTH-1:0] MAX_VAL = NATURAL ? {WIDTH{1'b1}}
                                                   : WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic             cin_en;
    logic             at_max;
    logic             over_max;
    logic [WIDTH-1:0] q_shl;
    logic [WIDTH-1:0] q_shr;
    logic [WIDTH-1:0] q_rol;
    logic [WIDTH-1:0] q_nxt;

`ifdef RV523_CASCADE_EN
    assign cin_en = cin;
    assign cout   = tc;
`else
    assign cin_en = 1'b1;
`endif

    // Range compare against MAX; with a full-range count q can never exceed it.
    generate
        if (NATURAL) begin : g_nat
            assign at_max   = (q == MAX_VAL);
            assign over_max = 1'b0;
        end else begin : g_mod
            assign at_max   = (q >= MAX_VAL);
            assign over_max = (q > MAX_VAL);
        end
    endgenerate

    // Shift/rotate datapaths; a 1-bit register has no interior bits to move.
    generate
        if (WIDTH == 1) begin : g_w1
            assign q_shl = sl_in;
            assign q_shr = sr_in;
            assign q_rol = q;
        end else begin : g_wn
            assign q_shl = {q[WIDTH-2:0], sl_in};
            assign q_shr = {sr_in, q[WIDTH-1:1]};
            assign q_rol = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    // Next-state selection.
    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_UP: begin
                if (cin_en) begin
                    q_nxt = at_max ? '0 : q + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (cin_en) begin
                    // Out-of-range loaded values re-enter the count at MAX.
                    q_nxt = ((q == '0) || over_max) ? MAX_VAL : q - WIDTH'(1);
                end
            end
            MODE_SHL:  q_nxt = q_shl;
            MODE_SHR:  q_nxt = q_shr;
            MODE_ROL:  q_nxt = q_rol;
            MODE_CLR:  q_nxt = '0;
            default:   q_nxt = q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_Q;
        end else if (ce) begin
            q <= q_nxt;
        end
    end

    // Terminal count: about to wrap in the current count direction.
    assign tc = ce & cin_en &
                (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & (q == '0)));

endmodule

// File: tb/tb_msi_univ_counter.sv
// ----------------------------------------------------------------------------
// tb_msi_univ_counter
//   Directed bench: a natural-wrap instance, a modulus-10 instance with a
//   non-zero reset value and, when RV523_CASCADE_EN is defined, a two-stage
//   ripple chain forming an 8-bit counter.
// ----------------------------------------------------------------------------
module tb_msi_univ_counter;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_UP   = 3'd2;
    localparam logic [2:0] M_DOWN = 3'd3;
    localparam logic [2:0] M_SHL  = 3'd4;
    localparam logic [2:0] M_SHR  = 3'd5;
    localparam logic [2:0] M_ROL  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    typedef struct {
        logic [2:0] mode;
        logic       ce;
        logic [3:0] d;
        logic       sl;
        logic       sr;
        logic       exp_tc;
        logic [3:0] exp_q;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sl_in;
    logic       sr_in;
    logic [3:0] q_n;
    logic       tc_n;
    logic [3:0] q_m;
    logic       tc_m;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    msi_univ_counter #(.WIDTH(4), .MODULUS(0), .RESET_VAL(0)) u_nat (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_n), .tc(tc_n)
`ifdef RV523_CASCADE_EN
        , .cin(1'b1), .cout()
`endif
    );

    msi_univ_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5)) u_m10 (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_m), .tc(tc_m)
`ifdef RV523_CASCADE_EN
        , .cin(1'b1), .cout()
`endif
    );

`ifdef RV523_CASCADE_EN
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, cout_lo, cout_hi;

    msi_univ_counter #(.WIDTH(4), .MODULUS(0), .RESET_VAL(0)) u_lo (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_lo), .tc(tc_lo),
        .cin(1'b1), .cout(cout_lo)
    );

    msi_univ_counter #(.WIDTH(4), .MODULUS(0), .RESET_VAL(0)) u_hi (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_hi), .tc(tc_hi),
        .cin(cout_lo), .cout(cout_hi)
    );
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one operation, check tc before the edge and q after it.
    task automatic apply(input bit sel_m10, input logic [2:0] m, input logic c,
                         input logic [3:0] dv, input logic sl, input logic sr,
                         input logic etc, input logic [3:0] eq, input string nm);
        @(negedge clk);
        mode  = m;
        ce    = c;
        d     = dv;
        sl_in = sl;
        sr_in = sr;
        #1;
        check({nm, ".tc"}, 32'(sel_m10 ? tc_m : tc_n), 32'(etc));
        @(posedge clk);
        #1;
        check({nm, ".q"}, 32'(sel_m10 ? q_m : q_n), 32'(eq));
    endtask

    vec_t tbl[$];

    initial begin
        // Natural-wrap instance: load/shift/rotate/clear, ce gating, down wrap.
        tbl.push_back('{M_LOAD, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 4'h9});
        tbl.push_back('{M_SHL,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2});
        tbl.push_back('{M_SHR,  1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h9});
        tbl.push_back('{M_ROL,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h3});
        tbl.push_back('{M_CLR,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{M_LOAD, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_UP,   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_UP,   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_UP,   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_LOAD, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_CLR,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_DOWN, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h6});
        tbl.push_back('{M_LOAD, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{M_DOWN, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF});
        tbl.push_back('{M_UP,   1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0});
        tbl.push_back('{M_LOAD, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF});
        tbl.push_back('{M_UP,   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF});
        tbl.push_back('{M_HOLD, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF});
        tbl.push_back('{M_SHL,  1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF});
        tbl.push_back('{M_SHR,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7});
        tbl.push_back('{M_ROL,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE});
        tbl.push_back('{M_ROL,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'hD});

        rst   = 1'b1;
        ce    = 1'b0;
        mode  = M_HOLD;
        d     = 4'h0;
        sl_in = 1'b0;
        sr_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.q_nat", 32'(q_n), 32'h0);
        check("rst.q_m10", 32'(q_m), 32'h5);
        check("rst.tc_nat", 32'(tc_n), 32'h0);
        rst = 1'b0;

        // Free-running up count through the natural wrap.
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, M_UP, 1'b1, 4'h0, 1'b0, 1'b0,
                  ((i % 16) == 15), 4'((i + 1) % 16), $sformatf("up%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(1'b0, tbl[i].mode, tbl[i].ce, tbl[i].d, tbl[i].sl, tbl[i].sr,
                  tbl[i].exp_tc, tbl[i].exp_q, $sformatf("vec%0d", i));
        end

        // Modulus-10 instance: wrap both ways and out-of-range recovery.
        apply(1'b1, M_LOAD, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 4'd8, "m10.ld8");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd9, "m10.up9");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, "m10.up0");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd1, "m10.up1");
        apply(1'b1, M_LOAD, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, "m10.ld0");
        apply(1'b1, M_DOWN, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd9, "m10.dn9");
        apply(1'b1, M_DOWN, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd8, "m10.dn8");
        apply(1'b1, M_LOAD, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd12, "m10.ld12a");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, "m10.up12");
        apply(1'b1, M_LOAD, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd12, "m10.ld12b");
        apply(1'b1, M_DOWN, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd9, "m10.dn12");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, "m10.upw");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd1, "m10.upa");
        apply(1'b1, M_UP,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd2, "m10.upb");

        // Asynchronous reset pulse between edges, counting resumes from RESET_VAL.
        @(negedge clk);
        mode = M_UP;
        ce   = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst.q_m10", 32'(q_m), 32'h5);
        check("arst.q_nat", 32'(q_n), 32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst.resume6", 32'(q_m), 32'h6);
        apply(1'b1, M_UP,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, "m10.up7");
        apply(1'b1, M_CLR, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "m10.clr");

`ifdef RV523_CASCADE_EN
        // Two chained stages count as one 8-bit counter.
        @(negedge clk);
        mode = M_CLR;
        ce   = 1'b1;
        @(negedge clk);
        mode = M_UP;
        for (int i = 0; i < 256; i++) begin
            #1;
            check($sformatf("casc.cnt%0d", i), 32'({q_hi, q_lo}), 32'(i));
            check($sformatf("casc.cout%0d", i), 32'(cout_lo), 32'((i % 16) == 15));
            @(negedge clk);
        end
        #1;
        check("casc.wrap", 32'({q_hi, q_lo}), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
